// File: rtl/lfsr32_pkg.sv
`default_nettype none
// lfsr32_pkg: shared polynomial taps, reset seed, step function and checker states.
// Rev 1.0
package lfsr32_pkg;

  localparam int LFSR_W = 32;

  localparam int TAP_HI = 31;
  localparam int TAP_B  = 21;
  localparam int TAP_C  = 1;
  localparam int TAP_D  = 0;

  // Bits that receive the feedback XOR; bit 31 is fed by the rotate itself.
  localparam logic [LFSR_W-1:0] TAP_MASK = (32'h1 << TAP_B) | (32'h1 << TAP_C) | (32'h1 << TAP_D);

  localparam logic [LFSR_W-1:0] RESET_SEED = 32'h0000_0001;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_t;

  function automatic logic [LFSR_W-1:0] lfsr32_next(input logic [LFSR_W-1:0] x);
    logic [LFSR_W-1:0] n;
    n         = x >> 1;
    n[TAP_HI] = x[0];
    n         = n ^ ({LFSR_W{x[0]}} & TAP_MASK);
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr32_checker.sv
`default_nettype none
// lfsr32_checker: self-synchronising PRBS receive checker for the 32-bit Galois LFSR stream.
// Rev 1.0
module lfsr32_checker
  import lfsr32_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_q,
  input  logic              clear_cnt,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [LFSR_W-1:0] expected
);

  localparam int MATCH_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = (UNLOCK_CNT < 1) ? 1 : $clog2(UNLOCK_CNT + 1);

  localparam logic [MATCH_W-1:0] LOCK_LAST   = MATCH_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0]  UNLOCK_LAST = MISS_W'(UNLOCK_CNT - 1);
  localparam logic [ERR_W-1:0]   ERR_MAX     = '1;

  lfsr_state_t        state;
  logic [MATCH_W-1:0] match_run;
  logic [MISS_W-1:0]  miss_run;

  logic in_is_zero;
  logic in_matches;

  assign in_is_zero = (in_q == '0);
  assign in_matches = (in_q == expected);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      expected  <= '0;
      match_run <= '0;
      miss_run  <= '0;
    end else begin
      err_pulse <= 1'b0;

      if (in_valid) begin
        case (state)
          SEARCH: begin
            if (!in_is_zero) begin
              expected  <= lfsr32_next(in_q);
              match_run <= '0;
              state     <= VERIFY;
            end
          end

          VERIFY: begin
            if (in_matches) begin
              expected  <= lfsr32_next(in_q);
              match_run <= match_run + 1'b1;
              if (match_run == LOCK_LAST) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_run <= '0;
              end
            end else if (!in_is_zero) begin
              expected  <= lfsr32_next(in_q);
              match_run <= '0;
            end else begin
              state <= SEARCH;
            end
          end

          LOCKED: begin
            // Flywheel on the local prediction; the received word never reseeds here.
            expected <= lfsr32_next(expected);
            if (in_matches) begin
              miss_run <= '0;
            end else begin
              err_pulse <= 1'b1;
              if (err_count != ERR_MAX) begin
                err_count <= err_count + 1'b1;
              end
              if (miss_run == UNLOCK_LAST) begin
                state    <= SEARCH;
                locked   <= 1'b0;
                miss_run <= '0;
              end else begin
                miss_run <= miss_run + 1'b1;
              end
            end
          end

          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end

      // Placed last so a clear wins over a same-edge increment.
      if (clear_cnt) begin
        err_count <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lfsr32_checker.sv
`default_nettype none
// tb_lfsr32_checker: directed self-checking bench for lfsr32_checker (default and saturating builds).
// Rev 1.0
module tb_lfsr32_checker;
  import lfsr32_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_q;
  logic        clear_cnt;

  logic        a_locked;
  logic        a_err_pulse;
  logic [15:0] a_err_count;
  logic [31:0] a_expected;

  logic        b_locked;
  logic        b_err_pulse;
  logic [3:0]  b_err_count;
  logic [31:0] b_expected;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] g;

  always #5 clk = ~clk;

  lfsr32_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_W(16)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_q      (in_q),
    .clear_cnt (clear_cnt),
    .locked    (a_locked),
    .err_pulse (a_err_pulse),
    .err_count (a_err_count),
    .expected  (a_expected)
  );

  lfsr32_checker #(.LOCK_CNT(4), .UNLOCK_CNT(32), .ERR_W(4)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_q      (in_q),
    .clear_cnt (clear_cnt),
    .locked    (b_locked),
    .err_pulse (b_err_pulse),
    .err_count (b_err_count),
    .expected  (b_expected)
  );

  function automatic logic [31:0] ref_f(input logic [31:0] x);
    logic [31:0] n;
    n     = x >> 1;
    n[31] = x[0];
    n[21] = n[21] ^ x[0];
    n[1]  = n[1] ^ x[0];
    n[0]  = n[0] ^ x[0];
    return n;
  endfunction

  task automatic step(input logic v, input logic [31:0] q, input logic clr);
    in_valid  = v;
    in_q      = q;
    clear_cnt = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic send_gen();
    step(1'b1, g, 1'b0);
    g = ref_f(g);
  endtask

  task automatic send_bad(input logic clr);
    step(1'b1, g ^ 32'h1, clr);
    g = ref_f(g);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_q      = '0;
    clear_cnt = 1'b0;

    // Reset state
    do_reset();
    chk("rst_locked", a_locked, 0);
    chk("rst_pulse", a_err_pulse, 0);
    chk("rst_count", a_err_count, 0);
    chk("rst_expected", a_expected, 0);

    // Lock on the generator sequence from seed 1
    step(1'b1, 32'h0000_0001, 1'b0);
    chk("seed_expected", a_expected, 32'h8020_0003);
    chk("seed_locked", a_locked, 0);
    step(1'b1, 32'h8020_0003, 1'b0);
    chk("m1_expected", a_expected, 32'hC030_0002);
    step(1'b1, 32'hC030_0002, 1'b0);
    chk("m2_expected", a_expected, 32'h6018_0001);
    step(1'b1, 32'h6018_0001, 1'b0);
    chk("m3_locked", a_locked, 0);
    step(1'b1, 32'hB02C_0003, 1'b0);
    chk("m4_locked", a_locked, 1);
    chk("m4_expected", a_expected, 32'hD836_0002);
    chk("m4_count", a_err_count, 0);
    g = 32'hD836_0002;

    // Single bit error while locked
    send_bad(1'b0);
    chk("err1_pulse", a_err_pulse, 1);
    chk("err1_count", a_err_count, 1);
    chk("err1_locked", a_locked, 1);
    chk("err1_flywheel", a_expected, g);
    send_gen();
    chk("err1_pulse_drop", a_err_pulse, 0);
    chk("err1_clean_expected", a_expected, g);
    send_gen();
    chk("err1_count_hold", a_err_count, 1);
    // Clear on a clean word does not disturb lock
    step(1'b1, g, 1'b1);
    g = ref_f(g);
    chk("clr_count", a_err_count, 0);
    chk("clr_locked", a_locked, 1);

    // Three consecutive errors drop lock
    send_bad(1'b0);
    chk("u1_locked", a_locked, 1);
    send_bad(1'b0);
    chk("u2_locked", a_locked, 1);
    chk("u2_count", a_err_count, 2);
    send_bad(1'b0);
    chk("u3_locked", a_locked, 0);
    chk("u3_count", a_err_count, 3);
    chk("u3_pulse", a_err_pulse, 1);
    // Relock after seed plus four matches
    for (int i = 0; i < 4; i++) begin
      send_gen();
      chk("relock_pending", a_locked, 0);
    end
    send_gen();
    chk("relock_locked", a_locked, 1);
    chk("relock_expected", a_expected, g);
    chk("relock_count", a_err_count, 3);

    // Lock-up word in SEARCH, zero mismatch in VERIFY
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h0, 1'b0);
    end
    chk("zero_locked", a_locked, 0);
    chk("zero_expected", a_expected, 0);
    step(1'b1, RESET_SEED, 1'b0);
    chk("zv_seed_expected", a_expected, 32'h8020_0003);
    step(1'b1, 32'h0, 1'b0);
    chk("zv_locked", a_locked, 0);
    g = 32'h8020_0003;
    for (int i = 0; i < 4; i++) begin
      send_gen();
    end
    chk("zv_after_search_locked", a_locked, 0);
    send_gen();
    chk("zv_relock", a_locked, 1);

    // Valid bubbles do not change lock timing in sample terms
    do_reset();
    g = RESET_SEED;
    for (int i = 0; i < 5; i++) begin
      send_gen();
      chk("bub_lock_timing", a_locked, (i == 4) ? 32'h1 : 32'h0);
      for (int k = 0; k <= (i % 3); k++) begin
        step(1'b0, 32'hDEAD_BEEF, 1'b0);
        chk("bub_gap_pulse", a_err_pulse, 0);
      end
    end
    chk("bub_expected_hold", a_expected, g);
    send_gen();
    chk("bub_count", a_err_count, 0);
    chk("bub_still_locked", a_locked, 1);

    // Saturating counter on the narrow instance, clear wins over increment
    do_reset();
    g = RESET_SEED;
    for (int i = 0; i < 5; i++) begin
      send_gen();
    end
    chk("sat_locked", b_locked, 1);
    for (int i = 0; i < 20; i++) begin
      send_bad(1'b0);
    end
    chk("sat_count", b_err_count, 4'hF);
    chk("sat_locked_after", b_locked, 1);
    send_bad(1'b1);
    chk("sat_clr_count", b_err_count, 0);
    chk("sat_clr_pulse", b_err_pulse, 1);
    chk("sat_clr_locked", b_locked, 1);
    send_bad(1'b0);
    chk("sat_post_clr_count", b_err_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
